// File: rtl/stall_ctrl_if.sv
// Hazard-detection bus between the pipeline and stall_ctrl.
// Carries the operand descriptors of the D stage, the destination/Tnew of the
// E and M stages, MDU issue info, and the resulting stall/enable/flush and
// MDU busy-tracker outputs.
//   master : pipeline side (drives stage info, receives stall decision)
//   slave  : stall_ctrl side
interface stall_ctrl_if;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic        D_is_md;
  logic [4:0]  E_wr_addr;
  logic [1:0]  E_tnew;
  logic [4:0]  M_wr_addr;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_type;
  logic        F_WrEn;
  logic        D_WrEn;
  logic        E_flush;
  logic        stall;
  logic        md_busy;
  logic [3:0]  md_count;
  logic [31:0] stall_cycles;

  modport master (
    output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
           E_wr_addr, E_tnew, M_wr_addr, M_tnew, E_md_start, E_md_type,
    input  F_WrEn, D_WrEn, E_flush, stall, md_busy, md_count, stall_cycles
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse, D_is_md,
           E_wr_addr, E_tnew, M_wr_addr, M_tnew, E_md_start, E_md_type,
    output F_WrEn, D_WrEn, E_flush, stall, md_busy, md_count, stall_cycles
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall controller.
// Detects RAW hazards between the D-stage operands and the E/M destinations
// using Tuse/Tnew, stalls D-stage MDU instructions while the MDU is busy, and
// keeps a saturating count of stalled cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - stall_ctrl_if.slave (stage info in; stall/enables/flush,
//           md_busy, md_count, stall_cycles out)
module stall_ctrl (
  input  logic         clk,
  input  logic         reset,
  stall_ctrl_if.slave  bus
);

  logic [3:0]  md_count_q,     md_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;

  // Register 0 never creates a hazard; Tuse == 3 marks an unused operand.
  always_comb begin
    stall_rs = (bus.D_rs_addr != 5'd0) && (bus.D_rs_tuse != 2'd3) &&
               (((bus.E_wr_addr == bus.D_rs_addr) && (bus.E_tnew > bus.D_rs_tuse)) ||
                ((bus.M_wr_addr == bus.D_rs_addr) && (bus.M_tnew > bus.D_rs_tuse)));
    stall_rt = (bus.D_rt_addr != 5'd0) && (bus.D_rt_tuse != 2'd3) &&
               (((bus.E_wr_addr == bus.D_rt_addr) && (bus.E_tnew > bus.D_rt_tuse)) ||
                ((bus.M_wr_addr == bus.D_rt_addr) && (bus.M_tnew > bus.D_rt_tuse)));
    stall_md = bus.D_is_md && (bus.E_md_start || (md_count_q != 4'd0));
    stall    = stall_rs | stall_rt | stall_md;
  end

  // A fresh issue always reloads, even over a busy count.
  always_comb begin
    md_count_d = md_count_q;
    if (bus.E_md_start)
      md_count_d = bus.E_md_type ? 4'd10 : 4'd5;
    else if (md_count_q != 4'd0)
      md_count_d = md_count_q - 4'd1;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_count_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      md_count_q     <= md_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.F_WrEn       = ~stall;
  assign bus.D_WrEn       = ~stall;
  assign bus.E_flush      = stall;
  assign bus.md_busy      = (md_count_q != 4'd0);
  assign bus.md_count     = md_count_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;
  logic clk;
  logic reset;

  stall_ctrl_if bus ();

  stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned errors;

  // Reference state: MDU cycles remaining and stalled-cycle total.
  int          m_count;
  longint      m_stalls;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit hazard(input logic [4:0] a, input logic [1:0] tuse);
    if (a == 0 || tuse == 3) return 1'b0;
    return (bus.E_wr_addr == a && bus.E_tnew > tuse) ||
           (bus.M_wr_addr == a && bus.M_tnew > tuse);
  endfunction

  function automatic bit exp_stall();
    return hazard(bus.D_rs_addr, bus.D_rs_tuse) ||
           hazard(bus.D_rt_addr, bus.D_rt_tuse) ||
           (bus.D_is_md && (bus.E_md_start || m_count > 0));
  endfunction

  task automatic idle();
    bus.D_rs_addr = 0; bus.D_rt_addr = 0;
    bus.D_rs_tuse = 3; bus.D_rt_tuse = 3;
    bus.D_is_md = 0;
    bus.E_wr_addr = 0; bus.E_tnew = 0;
    bus.M_wr_addr = 0; bus.M_tnew = 0;
    bus.E_md_start = 0; bus.E_md_type = 0;
    reset = 0;
  endtask

  // Called just after a falling edge with inputs applied: checks outputs,
  // then advances the model across the rising edge.
  task automatic tick();
    bit s;
    #1;
    s = exp_stall();
    check_eq("stall",        {31'd0, bus.stall},   {31'd0, s});
    check_eq("F_WrEn",       {31'd0, bus.F_WrEn},  {31'd0, ~s});
    check_eq("D_WrEn",       {31'd0, bus.D_WrEn},  {31'd0, ~s});
    check_eq("E_flush",      {31'd0, bus.E_flush}, {31'd0, s});
    check_eq("md_count",     {28'd0, bus.md_count}, m_count);
    check_eq("md_busy",      {31'd0, bus.md_busy}, {31'd0, m_count > 0});
    check_eq("stall_cycles", bus.stall_cycles, m_stalls[31:0]);
    @(posedge clk);
    if (reset) begin
      m_count  = 0;
      m_stalls = 0;
    end else begin
      if (s && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (bus.E_md_start) m_count = bus.E_md_type ? 10 : 5;
      else if (m_count > 0) m_count--;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  int stall_seen;

  initial begin
    checks = 0; errors = 0;
    m_count = 0; m_stalls = 0;
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    // Model state is known after this reset edge.
    tick();
    reset = 0;
    check_eq("reset_md_count", {28'd0, bus.md_count}, 32'd0);
    check_eq("reset_stall_cycles", bus.stall_cycles, 32'd0);

    // RS hazard against E with Tnew 2 > Tuse 0, then cleared by Tnew 0.
    idle();
    bus.D_rs_addr = 8; bus.D_rs_tuse = 0; bus.E_wr_addr = 8; bus.E_tnew = 2;
    #1;
    check_eq("rs_hazard_stall", {31'd0, bus.stall}, 32'd1);
    check_eq("rs_hazard_fwren", {31'd0, bus.F_WrEn}, 32'd0);
    check_eq("rs_hazard_flush", {31'd0, bus.E_flush}, 32'd1);
    tick();
    bus.E_tnew = 0;
    #1;
    check_eq("rs_tnew0_stall", {31'd0, bus.stall}, 32'd0);
    tick();

    // Register 0 never matches.
    idle();
    bus.D_rt_addr = 0; bus.D_rt_tuse = 0; bus.E_wr_addr = 0; bus.E_tnew = 2;
    #1;
    check_eq("rt_zero_stall", {31'd0, bus.stall}, 32'd0);
    tick();

    // Div issue: D MDU instruction stalls on start cycle plus 10 busy cycles.
    do_reset();
    idle();
    bus.D_is_md = 1; bus.E_md_start = 1; bus.E_md_type = 1;
    stall_seen = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (bus.stall) stall_seen++;
      if (i >= 1 && i <= 10)
        check_eq("div_count_seq", {28'd0, bus.md_count}, 11 - i);
      tick();
      bus.E_md_start = 0;
    end
    check_eq("div_stall_len", stall_seen, 32'd11);
    check_eq("div_stall_cycles", bus.stall_cycles, 32'd11);

    // Mult aborted by reset after 2 cycles.
    idle();
    bus.E_md_start = 1; bus.E_md_type = 0;
    tick();
    bus.E_md_start = 0;
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    check_eq("abort_md_count", {28'd0, bus.md_count}, 32'd0);
    check_eq("abort_md_busy", {31'd0, bus.md_busy}, 32'd0);
    check_eq("abort_stall_cycles", bus.stall_cycles, 32'd0);

    // Stall held 7 cycles.
    idle();
    bus.D_rt_addr = 5; bus.D_rt_tuse = 1; bus.M_wr_addr = 5; bus.M_tnew = 2;
    repeat (7) tick();
    idle();
    #1;
    check_eq("stall7_count", bus.stall_cycles, 32'd7);
    tick();

    // Saturation: preload near the top, then stall 3 cycles.
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    m_stalls = 64'hFFFF_FFFE;
    bus.D_rt_addr = 5; bus.D_rt_tuse = 1; bus.M_wr_addr = 5; bus.M_tnew = 2;
    repeat (3) tick();
    idle();
    #1;
    check_eq("stall_saturate", bus.stall_cycles, 32'hFFFF_FFFF);
    tick();

    // Div in progress at count 4, mult reissued -> 5.
    do_reset();
    idle();
    bus.E_md_start = 1; bus.E_md_type = 1;
    tick();
    bus.E_md_start = 0;
    repeat (6) tick();
    #1;
    check_eq("reload_pre_count", {28'd0, bus.md_count}, 32'd4);
    bus.E_md_start = 1; bus.E_md_type = 0;
    tick();
    bus.E_md_start = 0;
    #1;
    check_eq("reload_count", {28'd0, bus.md_count}, 32'd5);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.D_rs_addr  = 5'($urandom_range(0, 3));
      bus.D_rt_addr  = 5'($urandom_range(0, 3));
      bus.D_rs_tuse  = 2'($urandom);
      bus.D_rt_tuse  = 2'($urandom);
      bus.D_is_md    = ($urandom_range(0, 3) == 0);
      bus.E_wr_addr  = 5'($urandom_range(0, 3));
      bus.E_tnew     = 2'($urandom);
      bus.M_wr_addr  = 5'($urandom_range(0, 3));
      bus.M_tnew     = 2'($urandom);
      bus.E_md_start = ($urandom_range(0, 11) == 0);
      bus.E_md_type  = 1'($urandom);
      reset          = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have a clock input clk, 1 bit: all state updates on its rising edge.
REQ-002 SHALL have a reset input reset, 1 bit: synchronous, active-high.
REQ-003 SHALL have inputs D_rs_addr and D_rt_addr, 5 bits each: source register numbers of the instruction in D.
REQ-004 SHALL have inputs D_rs_tuse and D_rt_tuse, 2 bits each: cycles until D needs the operand; 3 means the operand is unused.
REQ-005 SHALL have an input D_is_md, 1 bit: the D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-006 SHALL have inputs E_wr_addr (5 bits) and E_tnew (2 bits): destination and remaining cycles to result, E stage.
REQ-007 SHALL have inputs M_wr_addr (5 bits) and M_tnew (2 bits): the same for the M stage.
REQ-008 SHALL have inputs E_md_start and E_md_type, 1 bit each: a mult/div issued in E this cycle; type 0 = mult, 1 = div.
REQ-009 SHALL have outputs F_WrEn, D_WrEn and E_flush, 1 bit each: enables for the PC and D register, and flush for the D->E register.
REQ-010 SHALL have outputs stall (1 bit), md_busy (1 bit) and md_count (4 bits): the stall decision and the MDU busy tracker.
REQ-011 SHALL have an output stall_cycles, 32 bits: performance counter of stalled cycles.

Function
REQ-012 SHALL compute stall_rs = (D_rs_addr != 0) && (D_rs_tuse != 3) && ((E_wr_addr == D_rs_addr && E_tnew > D_rs_tuse) || (M_wr_addr == D_rs_addr && M_tnew > D_rs_tuse)).
REQ-013 SHALL compute stall_rt identically, using D_rt_addr and D_rt_tuse.
REQ-014 SHALL compute stall_md = D_is_md && (E_md_start || md_busy).
REQ-015 SHALL drive stall combinationally as stall_rs | stall_rt | stall_md, with no registered delay.
REQ-016 SHALL drive F_WrEn = D_WrEn = ~stall and E_flush = stall in the same cycle.
REQ-017 SHALL load md_count on E_md_start: 5 for mult, 10 for div.
REQ-018 SHALL decrement md_count by 1 each cycle while it is nonzero and E_md_start is low.
REQ-019 SHALL hold md_count at 0 once it reaches 0 (no wrap).
REQ-020 SHALL drive md_busy = (md_count != 0), taken from the register.
REQ-021 SHALL reload md_count from E_md_start when it is asserted while md_count != 0; the new load wins.
REQ-022 SHALL increment stall_cycles by 1 on each rising edge where stall = 1.
REQ-023 SHALL saturate stall_cycles at 32'hFFFF_FFFF.
REQ-024 SHALL apply E_wr_addr == 0 or M_wr_addr == 0 with no effect, since register 0 never matches per REQ-012.
REQ-025 SHALL treat Tnew values as given, with no decrement: upstream pipeline registers supply stage-correct values.

Reset
REQ-026 SHALL clear md_count and stall_cycles to 0 on a rising clk edge with reset = 1.
REQ-027 SHALL give reset priority over E_md_start and over counting; reset mid-mult/div aborts busy tracking immediately.
REQ-028 SHALL drive md_busy = 0 in the cycle after reset. stall, F_WrEn, D_WrEn and E_flush stay combinational and follow their inputs during reset.
REQ-029 SHALL apply reset identically when asserted in any state.

Verification
REQ-030 SHALL cover: D_rs_addr=8, D_rs_tuse=0, E_wr_addr=8, E_tnew=2 -> stall=1, F_WrEn=0, D_WrEn=0, E_flush=1; with E_tnew=0 -> stall=0.
REQ-031 SHALL cover: D_rt_addr=0, D_rt_tuse=0, E_wr_addr=0, E_tnew=2 -> stall=0.
REQ-032 SHALL cover: E_md_start=1, E_md_type=1 for 1 cycle -> md_count reads 10, 9, ... 1 over 10 cycles, then 0; md_busy=1 for exactly 10 cycles; D_is_md=1 stalls for 11 cycles including the start cycle.
REQ-033 SHALL cover: mult started (count 5), reset asserted after 2 cycles -> md_count=0 and md_busy=0 next cycle; stall_cycles=0.
REQ-034 SHALL cover: stall held 7 cycles -> stall_cycles=7; preload near saturation via long stall (or force) at 32'hFFFF_FFFE plus 3 stall cycles -> 32'hFFFF_FFFF.
REQ-035 SHALL cover: div in progress (md_count=4) and E_md_start=1 with mult -> md_count=5 next cycle.
